// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: PC register, fetch FSM, hold buffer and IF/ID register.
// Optional performance counters are compiled in with PC_FETCH_PERF_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] redirect_count
`endif
);

  // state | meaning
  // IDLE  | post-reset bubble, no request
  // FETCH | request at PC outstanding
  // HOLD  | fetched word parked in hold buffer while decode stalls
  // DROP  | redirected; waiting out the old request, its data is discarded
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] drop_addr, drop_addr_nxt;
  logic [31:0] hold_pc, hold_pc_nxt;
  logic [31:0] hold_instr, hold_instr_nxt;
  logic        if_valid_nxt;
  logic [31:0] if_pc_nxt, if_instr_nxt;
  logic [31:0] target_aligned;
  logic        deliver;

  assign target_aligned = branch_target & ~32'h3;
  assign pc_plus4       = pc + 32'd4;
  assign imem_req       = rst_n & ((state == S_FETCH) | (state == S_DROP));
  assign imem_addr      = (state == S_DROP) ? drop_addr : pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      drop_addr  <= 32'h0;
      hold_pc    <= 32'h0;
      hold_instr <= 32'h0;
      if_valid   <= 1'b0;
      if_pc      <= 32'h0;
      if_instr   <= 32'h0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      drop_addr  <= drop_addr_nxt;
      hold_pc    <= hold_pc_nxt;
      hold_instr <= hold_instr_nxt;
      if_valid   <= if_valid_nxt;
      if_pc      <= if_pc_nxt;
      if_instr   <= if_instr_nxt;
    end
  end

  // The hold buffer is valid exactly while in HOLD, so leaving HOLD invalidates it.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    drop_addr_nxt  = drop_addr;
    hold_pc_nxt    = hold_pc;
    hold_instr_nxt = hold_instr;
    if_valid_nxt   = if_valid;
    if_pc_nxt      = if_pc;
    if_instr_nxt   = if_instr;
    deliver        = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        if (branch_taken) begin
          pc_nxt       = target_aligned;
          if_valid_nxt = 1'b0;
          if (!imem_ack) begin
            state_nxt     = S_DROP;
            drop_addr_nxt = pc;
          end
        end else if (imem_ack) begin
          pc_nxt = pc_plus4;
          if (stall) begin
            hold_pc_nxt    = pc;
            hold_instr_nxt = imem_rdata;
            state_nxt      = S_HOLD;
          end else begin
            deliver      = 1'b1;
            if_valid_nxt = 1'b1;
            if_pc_nxt    = pc;
            if_instr_nxt = imem_rdata;
          end
        end else if (!stall) begin
          if_valid_nxt = 1'b0;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          pc_nxt       = target_aligned;
          if_valid_nxt = 1'b0;
          state_nxt    = S_FETCH;
        end else if (!stall) begin
          deliver      = 1'b1;
          if_valid_nxt = 1'b1;
          if_pc_nxt    = hold_pc;
          if_instr_nxt = hold_instr;
          state_nxt    = S_FETCH;
        end
      end
      S_DROP: begin
        if (branch_taken) begin
          pc_nxt       = target_aligned;
          if_valid_nxt = 1'b0;
        end else if (!stall) begin
          if_valid_nxt = 1'b0;
        end
        if (imem_ack) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef PC_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count    <= 32'h0;
      redirect_count <= 32'h0;
    end else begin
      if (deliver)      fetch_count    <= fetch_count + 32'd1;
      if (branch_taken) redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: IF/ID deliveries go through an expected-value
// queue checked by a monitor; fetch-side outputs are checked directly.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        auto_ack;
  logic        man_ack;

  logic [31:0] w_pc_plus4, w_imem_addr, w_imem_rdata, w_if_pc, w_if_instr;
  logic        w_imem_req, w_if_valid;

`ifdef PC_FETCH_PERF_EN
  logic [31:0] fetch_count, redirect_count, w_fetch_count, w_redirect_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  assign imem_ack     = auto_ack ? imem_req : man_ack;
  assign imem_rdata   = mem_word(imem_addr);
  assign w_imem_rdata = mem_word(w_imem_addr);

  pc_fetch_unit #(.RESET_PC(32'h0000_0100)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_plus4(pc_plus4), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
`ifdef PC_FETCH_PERF_EN
    , .fetch_count(fetch_count), .redirect_count(redirect_count)
`endif
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(32'h0), .pc_plus4(w_pc_plus4), .imem_req(w_imem_req),
    .imem_addr(w_imem_addr), .imem_ack(w_imem_req), .imem_rdata(w_imem_rdata),
    .if_valid(w_if_valid), .if_pc(w_if_pc), .if_instr(w_if_instr)
`ifdef PC_FETCH_PERF_EN
    , .fetch_count(w_fetch_count), .redirect_count(w_redirect_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decode consumes IF/ID on a rising edge where if_valid=1 and stall=0.
  always @(negedge clk) begin
    if (if_valid === 1'b1 && stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ifid_unexpected: got pc %h instr %h expected nothing", if_pc, if_instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("ifid_pc", if_pc, e[63:32]);
        chk("ifid_instr", if_instr, e[31:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    auto_ack = 1'b1; man_ack = 1'b0;

    // reset and zero-wait streaming
    step(); step();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_pc_plus4", pc_plus4, 32'h104);
    push_exp(32'h100); push_exp(32'h104);
    rst_n = 1'b1;
    step();
    chk("s1_req", {31'h0, imem_req}, 32'h1);
    chk("s1_addr", imem_addr, 32'h100);
    chk("s1_if_valid", {31'h0, if_valid}, 32'h0);
    chk("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
    chk("wrap_plus4_0", w_pc_plus4, 32'h0);
    step();
    chk("s2_addr", imem_addr, 32'h104);
    chk("s2_if_pc", if_pc, 32'h100);
    chk("wrap_addr1", w_imem_addr, 32'h0);
    chk("wrap_plus4_1", w_pc_plus4, 32'h4);
    chk("wrap_if_pc", w_if_pc, 32'hFFFF_FFFC);
    step();
    chk("s3_addr", imem_addr, 32'h108);
    chk("s3_if_pc", if_pc, 32'h104);
    auto_ack = 1'b0;

    // redirect with ack in same cycle, then stall via hold buffer
    branch_taken = 1'b1; branch_target = 32'h200; man_ack = 1'b1;
    step();
    chk("br_ack_addr", imem_addr, 32'h200);
    chk("br_ack_if_valid", {31'h0, if_valid}, 32'h0);
    chk("br_ack_req", {31'h0, imem_req}, 32'h1);
    push_exp(32'h200);
    branch_taken = 1'b0; stall = 1'b1;
    step();
    man_ack = 1'b0;
    chk("hold_req_a", {31'h0, imem_req}, 32'h0);
    chk("hold_if_valid", {31'h0, if_valid}, 32'h0);
    step();
    chk("hold_req_b", {31'h0, imem_req}, 32'h0);
    step();
    chk("hold_req_c", {31'h0, imem_req}, 32'h0);
    stall = 1'b0;
    step();
    chk("rel_if_valid", {31'h0, if_valid}, 32'h1);
    chk("rel_if_pc", if_pc, 32'h200);
    chk("rel_addr", imem_addr, 32'h204);
    chk("rel_req", {31'h0, imem_req}, 32'h1);
    stall = 1'b1;
    step();
    chk("stall_keep_valid", {31'h0, if_valid}, 32'h1);
    chk("stall_keep_pc", if_pc, 32'h200);
    chk("stall_keep_instr", if_instr, mem_word(32'h200));
    stall = 1'b0;
    step();

    // redirect while request pending, re-redirect inside DROP
    branch_taken = 1'b1; branch_target = 32'h300; man_ack = 1'b1;
    step();
    chk("to300_addr", imem_addr, 32'h300);
    branch_target = 32'h500; man_ack = 1'b0;
    step();
    chk("drop_addr_a", imem_addr, 32'h300);
    chk("drop_req_a", {31'h0, imem_req}, 32'h1);
    chk("drop_plus4_a", pc_plus4, 32'h504);
    branch_target = 32'h403;
    step();
    chk("drop_addr_b", imem_addr, 32'h300);
    chk("drop_plus4_b", pc_plus4, 32'h404);
    branch_taken = 1'b0; man_ack = 1'b1;
    step();
    chk("after_drop_addr", imem_addr, 32'h400);
    chk("after_drop_valid", {31'h0, if_valid}, 32'h0);
    step();
    chk("d400_valid", {31'h0, if_valid}, 32'h1);
    chk("d400_pc", if_pc, 32'h400);

    // redirect + ack + stall in one cycle flushes IF/ID
    branch_taken = 1'b1; branch_target = 32'h600; stall = 1'b1;
    step();
    chk("bas_if_valid", {31'h0, if_valid}, 32'h0);
    chk("bas_addr", imem_addr, 32'h600);
    chk("bas_req", {31'h0, imem_req}, 32'h1);
    branch_taken = 1'b0; stall = 1'b0; man_ack = 1'b0; auto_ack = 1'b1;
    push_exp(32'h600); push_exp(32'h604);
    step(); step();
    auto_ack = 1'b0;
    chk("resume_addr", imem_addr, 32'h608);

    // reset with request pending; ack arriving in IDLE is ignored
    rst_n = 1'b0;
    #1;
    chk("rst_comb_req", {31'h0, imem_req}, 32'h0);
    step();
    chk("rst2_if_valid", {31'h0, if_valid}, 32'h0);
    chk("rst2_if_pc", if_pc, 32'h0);
    chk("rst2_addr", imem_addr, 32'h100);
`ifdef PC_FETCH_PERF_EN
    chk("rst2_fetch_count", fetch_count, 32'h0);
    chk("rst2_redirect_count", redirect_count, 32'h0);
`endif
    rst_n = 1'b1; man_ack = 1'b1;
    step();
    chk("idle_ack_if_valid", {31'h0, if_valid}, 32'h0);
    chk("idle_ack_addr", imem_addr, 32'h100);
    chk("idle_ack_req", {31'h0, imem_req}, 32'h1);
    push_exp(32'h100);
    step();
    man_ack = 1'b0;
    chk("post_rst_if_pc", if_pc, 32'h100);
    step();
`ifdef PC_FETCH_PERF_EN
    chk("fetch_count", fetch_count, 32'h1);
    chk("redirect_count", redirect_count, 32'h0);
`endif

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded at reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 stall  input  1  decode not ready; IF/ID outputs and PC hold.
REQ-005 branch_taken  input  1  redirect request from the branch resolver (select line of the PC mux).
REQ-006 branch_target  input  32  redirect address; bits [1:0] ignored, treated as 00.
REQ-007 pc_plus4  output  32  sequential candidate, current PC + 4, combinational.
REQ-008 imem_req  output  1  instruction fetch request.
REQ-009 imem_addr  output  32  fetch address, equal to the current PC.
REQ-010 imem_ack  input  1  fetch completion; imem_rdata valid in the same cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 if_valid / if_pc / if_instr  output  1/32/32  IF/ID pipeline register contents.

Function
REQ-013 States: IDLE, FETCH, HOLD, DROP, encoded in 2 bits.
REQ-014 IDLE: imem_req=0; unconditional transition to FETCH next cycle.
REQ-015 FETCH: imem_req=1, imem_addr=PC; req and addr stay stable until imem_ack=1.
REQ-016 FETCH, ack=1, stall=0, branch_taken=0: next-cycle if_valid=1, if_pc=PC, if_instr=imem_rdata; PC<=PC+4; remain in FETCH. Throughput is 1 instruction/cycle with zero-wait memory.
REQ-017 FETCH, ack=1, stall=1: capture rdata and PC into the hold buffer; PC<=PC+4; go to HOLD; imem_req=0 while in HOLD.
REQ-018 HOLD, stall=0: move the hold buffer to IF/ID (if_valid=1); go to FETCH.
REQ-019 stall=1 with no delivery: if_valid, if_pc and if_instr hold their values.
REQ-020 branch_taken=1, in any non-IDLE state and regardless of stall, takes priority over all other events:
- PC<=branch_target&~3
- if_valid<=0
- hold buffer invalidated
REQ-021 branch_taken=1 while in FETCH with ack=0: go to DROP.
- imem_req stays 1 and imem_addr keeps the old address until ack.
- The acked data is discarded.
- Then go to FETCH at the target.
REQ-022 branch_taken=1 with ack=1 in the same cycle: data discarded; next state FETCH at the target.
REQ-023 branch_taken=1 while in DROP: PC is updated to the new target; state stays DROP.
REQ-024 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000, with no flag.
REQ-025 pc_plus4 is always PC+4, and the PC update on delivery equals pc_plus4.

Reset
REQ-026 rst_n=0 at a rising edge sets: PC=RESET_PC, state=IDLE, if_valid=0, if_pc=0, if_instr=0, hold buffer invalid, imem_req=0 (also forced 0 combinationally while rst_n=0).
REQ-027 Reset mid-request abandons the outstanding fetch without waiting for imem_ack; an ack arriving in IDLE is ignored.

Configuration
REQ-028 Macro PC_FETCH_PERF_EN, when defined, adds the outputs fetch_count[31:0] and redirect_count[31:0].
- fetch_count increments once per instruction written to IF/ID with if_valid=1.
- redirect_count increments once per cycle with branch_taken=1.
- Both counters reset to 0 and wrap at 2^32.
REQ-029 Without PC_FETCH_PERF_EN, these ports and counters are absent and all other behaviour is identical.

Verification
REQ-030 Reset, zero-wait memory (ack tied to req), RESET_PC=0x100 -> imem_addr 0x100, 0x104, 0x108 on consecutive cycles; if_pc lags by one cycle.
REQ-031 Ack at addr 0x200 with stall=1 for 3 cycles -> imem_req=0 during stall; if_pc=0x200 appears the cycle after stall drops; next imem_addr=0x204.
REQ-032 branch_taken=1, target 0x403, while a request to 0x300 is pending, ack 2 cycles later -> 0x300 data never in IF/ID; next imem_addr=0x400.
REQ-033 branch_taken=1 and ack in the same cycle with stall=1 -> if_valid=0 next cycle; fetch resumes at the target.
REQ-034 RESET_PC=0xFFFF_FFFC, one delivery -> next imem_addr=0x0, pc_plus4=0x4.
REQ-035 rst_n=0 during FETCH with req pending -> imem_req=0 the same cycle; state IDLE; with PC_FETCH_PERF_EN, both counters read 0.
